// File: rtl/axi_port_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : axi_port_arbiter_if
// Description : Bundle of requester (IF, LS), bridge-side and debug signals
//               around axi_port_arbiter.
//               slave  : arbiter view (takes requests, drives the bridge).
//               master : environment view (requesters and bridge).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  // Instruction fetch requester (read only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_rvalid;
  // Load/store requester
  logic                  ls_rd_req;
  logic                  ls_wr_req;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic [7:0]            ls_wmask;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_rvalid;
  logic                  ls_wready;
  // Bridge request port
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_rd_valid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rvalid;
  logic                  m_wr_valid;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [7:0]            m_wmask;
  logic                  m_wready;
  // Debug: 0 idle, 1 IF, 2 LS read, 3 LS write
  logic [1:0]            owner;

  modport slave (
    input  if_req, if_addr,
    input  ls_rd_req, ls_wr_req, ls_addr, ls_wdata, ls_wmask,
    input  m_rdata, m_rvalid, m_wready,
    output if_rdata, if_rvalid,
    output ls_rdata, ls_rvalid, ls_wready,
    output m_addr, m_rd_valid, m_wr_valid, m_wdata, m_wmask,
    output owner
  );

  modport master (
    output if_req, if_addr,
    output ls_rd_req, ls_wr_req, ls_addr, ls_wdata, ls_wmask,
    output m_rdata, m_rvalid, m_wready,
    input  if_rdata, if_rvalid,
    input  ls_rdata, ls_rvalid, ls_wready,
    input  m_addr, m_rd_valid, m_wr_valid, m_wdata, m_wmask,
    input  owner
  );
endinterface
`default_nettype wire

// File: rtl/axi_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : axi_port_arbiter
// Description : Shares the bridge request port between the instruction fetch
//               unit (reads) and the load/store unit (reads and writes).
//               One whole transaction is granted at a time, its command is
//               latched and forwarded, and the response is routed back to the
//               owner only. Round-robin priority between IF and LS.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus        - axi_port_arbiter_if.slave (requesters, bridge,
//                            owner debug code)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter bit IF_FIRST   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  axi_port_arbiter_if.slave  bus
);

  // Encoding doubles as the owner debug code.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_LS_RD = 2'd2,
    S_LS_WR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  prio_q,  prio_d;    // 1: IF preferred on a tie
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;

  logic if_cand;
  logic ls_cand;
  logic if_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= IF_FIRST;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;

    if_cand = bus.if_req;
    ls_cand = bus.ls_rd_req | bus.ls_wr_req;
    if_wins = if_cand & (~ls_cand | prio_q);

    case (state_q)
      S_IDLE: begin
        if (if_wins) begin
          state_d = S_IF_RD;
          addr_d  = bus.if_addr;
        end else if (ls_cand) begin
          addr_d = bus.ls_addr;
          // A pending write is taken before a pending read from LS.
          if (bus.ls_wr_req) begin
            state_d = S_LS_WR;
            wdata_d = bus.ls_wdata;
            wmask_d = bus.ls_wmask;
          end else begin
            state_d = S_LS_RD;
          end
        end
      end
      // Completion always returns to idle, which guarantees one idle cycle
      // between grants, and hands priority to the other requester.
      S_IF_RD: begin
        if (bus.m_rvalid) begin
          state_d = S_IDLE;
          prio_d  = 1'b0;
        end
      end
      S_LS_RD: begin
        if (bus.m_rvalid) begin
          state_d = S_IDLE;
          prio_d  = 1'b1;
        end
      end
      S_LS_WR: begin
        if (bus.m_wready) begin
          state_d = S_IDLE;
          prio_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bridge side is driven only from latched values.
  assign bus.m_addr     = addr_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.m_wmask    = wmask_q;
  assign bus.m_rd_valid = (state_q == S_IF_RD) | (state_q == S_LS_RD);
  assign bus.m_wr_valid = (state_q == S_LS_WR);
  assign bus.owner      = state_q;

  // Response routing: pulses reach only the current owner; stray responses
  // in any other state are dropped.
  assign bus.if_rdata  = bus.m_rdata;
  assign bus.ls_rdata  = bus.m_rdata;
  assign bus.if_rvalid = bus.m_rvalid & (state_q == S_IF_RD);
  assign bus.ls_rvalid = bus.m_rvalid & (state_q == S_LS_RD);
  assign bus.ls_wready = bus.m_wready & (state_q == S_LS_WR);

endmodule
`default_nettype wire

// File: tb/tb_axi_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_port_arbiter
// Description : Self-checking bench for axi_port_arbiter: single-cycle
//               arbitration vectors, directed multi-cycle sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IF_FIRST  (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       i_if;
    logic       i_rd;
    logic       i_wr;
    logic [1:0] e_owner;
  } vec_t;
  vec_t vecs[8];

  // Reference model state (random phase)
  int          exp_owner;   // 0 none, 1 IF, 2 LS read, 3 LS write
  bit          pref_if;
  logic [63:0] exp_addr, exp_wdata;
  logic [7:0]  exp_wmask;
  bit          exp_if_rv, exp_ls_rv, exp_ls_wr;
  int          r, kind;
  logic [1:0]  who;
  logic [63:0] exp_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ls_rd_req = 1'b0;
    bus.ls_wr_req = 1'b0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.ls_wmask  = '0;
    bus.m_rdata   = '0;
    bus.m_rvalid  = 1'b0;
    bus.m_wready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant, holds it lat cycles, completes it with the
  // matching response and checks routing and the following idle cycle.
  task automatic run_txn(input int lat, output logic [1:0] owner_seen);
    int guard = 0;
    while (bus.owner == 2'd0 && guard < 10) begin
      tick();
      guard++;
    end
    chk("grant_seen", {63'd0, bus.owner != 2'd0}, 64'd1);
    owner_seen = bus.owner;
    repeat (lat - 1) tick();
    bus.m_rdata = 64'hA5A5_0000 + 64'(owner_seen);
    if (bus.m_wr_valid) bus.m_wready = 1'b1;
    else                bus.m_rvalid = 1'b1;
    #1;
    chk("route_if_rvalid", {63'd0, bus.if_rvalid}, {63'd0, owner_seen == 2'd1});
    chk("route_ls_rvalid", {63'd0, bus.ls_rvalid}, {63'd0, owner_seen == 2'd2});
    chk("route_ls_wready", {63'd0, bus.ls_wready}, {63'd0, owner_seen == 2'd3});
    tick();
    bus.m_rvalid = 1'b0;
    bus.m_wready = 1'b0;
    chk("idle_gap_owner", 64'(bus.owner), 64'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    clear_inputs();
    tick();
    tick();
    chk("rst_owner",    64'(bus.owner), 64'd0);
    chk("rst_rd_valid", 64'(bus.m_rd_valid), 64'd0);
    chk("rst_wr_valid", 64'(bus.m_wr_valid), 64'd0);
    chk("rst_m_addr",   bus.m_addr, 64'd0);
    chk("rst_m_wdata",  bus.m_wdata, 64'd0);
    chk("rst_m_wmask",  64'(bus.m_wmask), 64'd0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rst_ls_wready", 64'(bus.ls_wready), 64'd0);
    rst = 1'b0;

    // ---------------- arbitration vectors from reset (IF preferred) ----
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd2};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd3};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.if_addr   = 64'h1000 + 64'(i);
      bus.ls_addr   = 64'h2000 + 64'(i);
      bus.ls_wdata  = 64'h3000 + 64'(i);
      bus.ls_wmask  = 8'(i + 1);
      bus.if_req    = vecs[i].i_if;
      bus.ls_rd_req = vecs[i].i_rd;
      bus.ls_wr_req = vecs[i].i_wr;
      #1;
      chk("vec_no_early_valid", 64'(bus.m_rd_valid | bus.m_wr_valid), 64'd0);
      tick();
      exp_a = (vecs[i].e_owner == 2'd1) ? 64'h1000 + 64'(i) :
              (vecs[i].e_owner == 2'd0) ? 64'd0 : 64'h2000 + 64'(i);
      chk("vec_owner", 64'(bus.owner), 64'(vecs[i].e_owner));
      chk("vec_rd_valid", 64'(bus.m_rd_valid),
          {63'd0, vecs[i].e_owner == 2'd1 || vecs[i].e_owner == 2'd2});
      chk("vec_wr_valid", 64'(bus.m_wr_valid), {63'd0, vecs[i].e_owner == 2'd3});
      chk("vec_m_addr", bus.m_addr, exp_a);
    end

    // ---------------- IF-only read ----------------
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_0000;
    #1;
    chk("ifrd_latency0", 64'(bus.m_rd_valid), 64'd0);
    tick();
    chk("ifrd_owner", 64'(bus.owner), 64'd1);
    chk("ifrd_rd_valid", 64'(bus.m_rd_valid), 64'd1);
    chk("ifrd_m_addr", bus.m_addr, 64'h8000_0000);
    tick();
    chk("ifrd_no_early_pulse", 64'(bus.if_rvalid), 64'd0);
    tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 64'h1122_3344_5566_7788;
    #1;
    chk("ifrd_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("ifrd_if_rdata", bus.if_rdata, 64'h1122_3344_5566_7788);
    chk("ifrd_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    tick();
    bus.m_rvalid = 1'b0;
    bus.if_req   = 1'b0;
    chk("ifrd_owner_back", 64'(bus.owner), 64'd0);
    chk("ifrd_rd_valid_low", 64'(bus.m_rd_valid), 64'd0);

    // ---------------- requester drops mid-grant ----------------
    bus.if_req = 1'b1;
    tick();
    bus.if_req = 1'b0;
    tick();
    bus.m_rvalid = 1'b1;
    #1;
    chk("drop_still_pulses", 64'(bus.if_rvalid), 64'd1);
    tick();
    bus.m_rvalid = 1'b0;
    chk("drop_owner_back", 64'(bus.owner), 64'd0);

    // ---------------- LS write with latch check ----------------
    bus.ls_wr_req = 1'b1;
    bus.ls_addr   = 64'h8000_1000;
    bus.ls_wdata  = 64'hDEAD_BEEF;
    bus.ls_wmask  = 8'h0F;
    tick();
    chk("lswr_owner", 64'(bus.owner), 64'd3);
    chk("lswr_wmask", 64'(bus.m_wmask), 64'h0F);
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      chk("lswr_wr_valid", 64'(bus.m_wr_valid), 64'd1);
      chk("lswr_rd_valid", 64'(bus.m_rd_valid), 64'd0);
      chk("lswr_addr_latched", bus.m_addr, 64'h8000_1000);
      chk("lswr_wdata_latched", bus.m_wdata, 64'hDEAD_BEEF);
    end
    bus.m_wready = 1'b1;
    #1;
    chk("lswr_ls_wready", 64'(bus.ls_wready), 64'd1);
    chk("lswr_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    tick();
    bus.m_wready  = 1'b0;
    bus.ls_wr_req = 1'b0;
    chk("lswr_owner_back", 64'(bus.owner), 64'd0);
    chk("lswr_wr_valid_low", 64'(bus.m_wr_valid), 64'd0);

    // ---------------- contention: alternation IF, LS, IF, LS ----------
    do_reset();
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h100;
    bus.ls_rd_req = 1'b1;
    bus.ls_addr   = 64'h200;
    for (int k = 0; k < 4; k++) begin
      run_txn(2, who);
      chk("rr_order", 64'(who), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    bus.if_req    = 1'b0;
    bus.ls_rd_req = 1'b0;

    // ---------------- LS read+write together: write first ----------
    do_reset();
    bus.ls_rd_req = 1'b1;
    bus.ls_wr_req = 1'b1;
    bus.ls_addr   = 64'h300;
    run_txn(3, who);
    chk("rdwr_first_write", 64'(who), 64'd3);
    bus.ls_wr_req = 1'b0;
    run_txn(2, who);
    chk("rdwr_then_read", 64'(who), 64'd2);
    bus.ls_rd_req = 1'b0;

    // ---------------- reset during S_IF_RD ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h400;
    tick();
    chk("rstmid_owner_pre", 64'(bus.owner), 64'd1);
    rst        = 1'b1;
    bus.if_req = 1'b0;
    tick();
    chk("rstmid_owner", 64'(bus.owner), 64'd0);
    chk("rstmid_rd_valid", 64'(bus.m_rd_valid), 64'd0);
    chk("rstmid_m_addr", bus.m_addr, 64'd0);
    rst          = 1'b0;
    bus.m_rvalid = 1'b1;
    #1;
    chk("rstmid_no_if_pulse", 64'(bus.if_rvalid), 64'd0);
    chk("rstmid_no_ls_pulse", 64'(bus.ls_rvalid), 64'd0);
    tick();
    bus.m_rvalid = 1'b0;
    chk("rstmid_owner_after", 64'(bus.owner), 64'd0);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    exp_owner = 0;
    pref_if   = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_owner", 64'(bus.owner), 64'(exp_owner));
      chk("rnd_rd_valid", 64'(bus.m_rd_valid), {63'd0, exp_owner == 1 || exp_owner == 2});
      chk("rnd_wr_valid", 64'(bus.m_wr_valid), {63'd0, exp_owner == 3});
      if (exp_owner != 0) chk("rnd_m_addr", bus.m_addr, exp_addr);
      if (exp_owner == 3) begin
        chk("rnd_m_wdata", bus.m_wdata, exp_wdata);
        chk("rnd_m_wmask", 64'(bus.m_wmask), 64'(exp_wmask));
      end
      // Bridge: completes the current grant at random, and sometimes
      // sends a response of the wrong kind that must be dropped.
      bus.m_rvalid = 1'b0;
      bus.m_wready = 1'b0;
      bus.m_rdata  = {$urandom, $urandom};
      r = int'($urandom_range(0, 9));
      if (exp_owner != 0 && r < 3) begin
        if (exp_owner == 3) bus.m_wready = 1'b1;
        else                bus.m_rvalid = 1'b1;
      end else if (r == 9) begin
        if (exp_owner == 3)      bus.m_rvalid = 1'b1;
        else if (exp_owner != 0) bus.m_wready = 1'b1;
        else if ($urandom_range(0, 1) == 1) bus.m_rvalid = 1'b1;
        else                     bus.m_wready = 1'b1;
      end
      // Requesters: new requests when idle; scramble buses while granted.
      if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {$urandom, $urandom};
      end else if (exp_owner == 1) begin
        bus.if_addr = {$urandom, $urandom};
      end
      if (!bus.ls_rd_req && !bus.ls_wr_req && $urandom_range(0, 3) == 0) begin
        kind          = int'($urandom_range(0, 2));
        bus.ls_rd_req = (kind != 1);
        bus.ls_wr_req = (kind != 0);
        bus.ls_addr   = {$urandom, $urandom};
        bus.ls_wdata  = {$urandom, $urandom};
        bus.ls_wmask  = 8'($urandom);
      end else if (exp_owner >= 2) begin
        bus.ls_addr  = {$urandom, $urandom};
        bus.ls_wdata = {$urandom, $urandom};
        bus.ls_wmask = 8'($urandom);
      end
      #1;
      exp_if_rv = bus.m_rvalid && exp_owner == 1;
      exp_ls_rv = bus.m_rvalid && exp_owner == 2;
      exp_ls_wr = bus.m_wready && exp_owner == 3;
      chk("rnd_if_rvalid", 64'(bus.if_rvalid), {63'd0, exp_if_rv});
      chk("rnd_ls_rvalid", 64'(bus.ls_rvalid), {63'd0, exp_ls_rv});
      chk("rnd_ls_wready", 64'(bus.ls_wready), {63'd0, exp_ls_wr});
      if (exp_if_rv) chk("rnd_if_rdata", bus.if_rdata, bus.m_rdata);
      if (exp_ls_rv) chk("rnd_ls_rdata", bus.ls_rdata, bus.m_rdata);
      // Model: whole-transaction ownership with round-robin hand-over.
      if (exp_owner == 0) begin
        if (bus.if_req && (!(bus.ls_rd_req || bus.ls_wr_req) || pref_if)) begin
          exp_owner = 1;
          exp_addr  = bus.if_addr;
        end else if (bus.ls_wr_req) begin
          exp_owner = 3;
          exp_addr  = bus.ls_addr;
          exp_wdata = bus.ls_wdata;
          exp_wmask = bus.ls_wmask;
        end else if (bus.ls_rd_req) begin
          exp_owner = 2;
          exp_addr  = bus.ls_addr;
        end
      end else if (exp_if_rv) begin
        exp_owner  = 0;
        pref_if    = 1'b0;
        bus.if_req = 1'b0;
      end else if (exp_ls_rv) begin
        exp_owner     = 0;
        pref_if       = 1'b1;
        bus.ls_rd_req = 1'b0;
      end else if (exp_ls_wr) begin
        exp_owner     = 0;
        pref_if       = 1'b1;
        bus.ls_wr_req = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
